// File: rtl/ps2_scan_display_pkg.sv
// ps2_scan_display_pkg
//   Shared definitions for the PS/2 scancode display block:
//   - rx_state_e     : receiver FSM states
//   - PREFIX_EXT/BRK : scancode prefix bytes (E0 extended, F0 break)
//   - SEG_BLANK      : all-segments-off glyph (active-high form)
//   - HEX_GLYPH      : 16-entry hex glyph table, gfedcba, active-high
//   - apply_polarity : converts an active-high glyph to the pin polarity
package ps2_scan_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 0 is the rightmost element: 0..9, A, b, C, d, E, F.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  function automatic logic [6:0] apply_polarity(input logic [6:0] seg, input bit active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg
//   Combinational hex digit to 7-segment glyph decoder.
//   Ports:
//     hex_i [3:0] : nibble to display
//     seg_o [6:0] : glyph, gfedcba order, active-high (1 = segment lit)
module hex_to_7seg
  import ps2_scan_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_GLYPH[hex_i];
  end

endmodule

// File: rtl/ps2_scan_display.sv
// ps2_scan_display
//   Receives PS/2 keyboard frames, assembles scancodes (with E0/F0
//   prefixes) and shows the most recent codes on 7-segment digits.
//   Ports:
//     clk        : system clock, all logic on its rising edge
//     rst        : asynchronous active-low reset
//     SCL, SDA   : PS/2 clock and data lines, asynchronous to clk
//     seg_out    : 2 digits per history byte, digit d in [7d+6:7d], gfedcba
//     code_valid : one-cycle pulse when a complete scancode arrives
//     code_byte  : final byte of the last completed scancode
//     extended   : E0 prefix seen on the last completed scancode
//     released   : F0 prefix seen on the last completed scancode
//     frame_err  : one-cycle pulse on parity, stop-bit or timeout error
module ps2_scan_display
  import ps2_scan_display_pkg::*;
#(
  parameter int NUM_BYTES      = 2,
  parameter int TIMEOUT_CYC    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SHOW_BREAK     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SCL,
  input  logic                     SDA,
  output logic [14*NUM_BYTES-1:0]  seg_out,
  output logic                     code_valid,
  output logic [7:0]               code_byte,
  output logic                     extended,
  output logic                     released,
  output logic                     frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam bit ACTIVE_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] DIGIT_OFF = apply_polarity(SEG_BLANK, ACTIVE_LOW);
  localparam logic [14*NUM_BYTES-1:0] SEG_RESET = {2*NUM_BYTES{DIGIT_OFF}};

  // Synchroniser chains plus one extra SCL stage for edge detection
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TW-1:0]   timeout_q, timeout_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;

  logic            code_valid_q, code_valid_d;
  logic [7:0]      code_byte_q, code_byte_d;
  logic            extended_q, extended_d;
  logic            released_q, released_d;
  logic            frame_err_q, frame_err_d;

  logic [NUM_BYTES-1:0][7:0] hist_byte_q, hist_byte_d;
  logic [NUM_BYTES-1:0]      hist_vld_q, hist_vld_d;

  logic [14*NUM_BYTES-1:0]   seg_q, seg_d;
  logic [2*NUM_BYTES-1:0][6:0] glyph;

  logic scl_fall;
  logic sda_bit;
  logic accept;

  assign scl_fall = scl_prev_q & ~scl_s2_q;
  assign sda_bit  = sda_s2_q;

  // Receiver FSM, prefix tracking and history shift. A byte is accepted
  // on the stop-bit edge; the resulting code and history update are
  // registered, so they become visible in the following cycle.
  always_comb begin
    scl_s1_d     = SCL;
    scl_s2_d     = scl_s1_q;
    scl_prev_d   = scl_s2_q;
    sda_s1_d     = SDA;
    sda_s2_d     = sda_s1_q;

    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    code_valid_d = 1'b0;
    code_byte_d  = code_byte_q;
    extended_d   = extended_q;
    released_d   = released_q;
    frame_err_d  = 1'b0;
    hist_byte_d  = hist_byte_q;
    hist_vld_d   = hist_vld_q;
    accept       = 1'b0;

    if (state_q == ST_IDLE || scl_fall) begin
      timeout_d = '0;
    end else begin
      timeout_d = timeout_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (scl_fall && !sda_bit) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (scl_fall) begin
          shift_d   = {sda_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (scl_fall) begin
          parity_d = sda_bit;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (scl_fall) begin
          state_d = ST_IDLE;
          // Odd parity across data plus parity bit, and a high stop bit
          if (sda_bit && (^{shift_q, parity_q})) begin
            accept = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A stalled PS/2 clock abandons the partial frame
    if (state_q != ST_IDLE && !scl_fall && timeout_q == TO_LAST) begin
      state_d     = ST_IDLE;
      timeout_d   = '0;
      frame_err_d = 1'b1;
    end

    if (accept) begin
      if (shift_q == PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        code_valid_d = 1'b1;
        code_byte_d  = shift_q;
        extended_d   = ext_q;
        released_d   = brk_q;
        ext_d        = 1'b0;
        brk_d        = 1'b0;
        if (!brk_q || (SHOW_BREAK != 0)) begin
          for (int k = NUM_BYTES - 1; k > 0; k--) begin
            hist_byte_d[k] = hist_byte_q[k-1];
            hist_vld_d[k]  = hist_vld_q[k-1];
          end
          hist_byte_d[0] = shift_q;
          hist_vld_d[0]  = 1'b1;
        end
      end
    end

    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  // Two decoders per history entry: low nibble then high nibble
  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_digit
    hex_to_7seg u_lo (
      .hex_i (hist_byte_q[g][3:0]),
      .seg_o (glyph[2*g])
    );
    hex_to_7seg u_hi (
      .hex_i (hist_byte_q[g][7:4]),
      .seg_o (glyph[2*g+1])
    );
  end

  // Invalid entries are blanked before polarity is applied
  always_comb begin
    seg_d = SEG_RESET;
    for (int k = 0; k < NUM_BYTES; k++) begin
      seg_d[14*k +: 7]     = apply_polarity(hist_vld_q[k] ? glyph[2*k]   : SEG_BLANK, ACTIVE_LOW);
      seg_d[14*k + 7 +: 7] = apply_polarity(hist_vld_q[k] ? glyph[2*k+1] : SEG_BLANK, ACTIVE_LOW);
    end
  end

  // Synchronisers reset to the idle-high line level so reset release
  // cannot look like a falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_prev_q   <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      timeout_q    <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      code_valid_q <= 1'b0;
      code_byte_q  <= 8'h00;
      extended_q   <= 1'b0;
      released_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      hist_byte_q  <= '0;
      hist_vld_q   <= '0;
      seg_q        <= SEG_RESET;
    end else begin
      scl_s1_q     <= scl_s1_d;
      scl_s2_q     <= scl_s2_d;
      scl_prev_q   <= scl_prev_d;
      sda_s1_q     <= sda_s1_d;
      sda_s2_q     <= sda_s2_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      timeout_q    <= timeout_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      code_valid_q <= code_valid_d;
      code_byte_q  <= code_byte_d;
      extended_q   <= extended_d;
      released_q   <= released_d;
      frame_err_q  <= frame_err_d;
      hist_byte_q  <= hist_byte_d;
      hist_vld_q   <= hist_vld_d;
      seg_q        <= seg_d;
    end
  end

  assign seg_out    = seg_q;
  assign code_valid = code_valid_q;
  assign code_byte  = code_byte_q;
  assign extended   = extended_q;
  assign released   = released_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_scan_display.md
PS2_SCAN_DISPLAY -- requirements
Module: ps2_scan_display

Interface
REQ-001 Parameter NUM_BYTES, default 2, number of scancode history bytes shown; each byte drives 2 hex digits.
REQ-002 Parameter TIMEOUT_CYC, default 50000, clk cycles without a PS/2 clock falling edge before an incomplete frame is aborted.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1, 1 = segment on is driven 0.
REQ-004 Parameter SHOW_BREAK, default 0, 1 = break (released) codes also enter the history.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 SCL  in  1  PS/2 clock line, asynchronous to clk.
REQ-008 SDA  in  1  PS/2 data line, asynchronous to clk.
REQ-009 seg_out  out  14*NUM_BYTES  digit d in bits [7d+6:7d], order gfedcba; digit 0 = low nibble of newest byte.
REQ-010 code_valid  out  1  one-cycle pulse, completed scancode.
REQ-011 code_byte  out  8  final byte of the completed scancode, held until next code_valid.
REQ-012 extended  out  1  E0 prefix present on the completed code, held with code_byte.
REQ-013 released  out  1  F0 prefix present on the completed code, held with code_byte.
REQ-014 frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-015 SCL and SDA each pass through a 2-flop synchroniser; a falling edge is synced SCL 1 in previous cycle and 0 in current cycle.
REQ-016 Receiver FSM states IDLE, DATA, PARITY, STOP; one bit sampled from synced SDA per falling edge.
REQ-017 IDLE: falling edge with SDA=0 -> DATA, bit counter 0; SDA=1 -> stay IDLE, no error.
REQ-018 DATA: 8 bits shifted in LSB first; after the 8th -> PARITY.
REQ-019 PARITY: sampled bit stored; -> STOP.
REQ-020 STOP: byte accepted iff stop bit = 1 and data+parity has odd count of ones; otherwise frame_err pulse, byte discarded; -> IDLE in both cases.
REQ-021 Timeout counter clears on every falling edge and in IDLE; reaching TIMEOUT_CYC outside IDLE -> IDLE, frame_err pulse, partial byte discarded.
REQ-022 Accepted byte 0xE0 sets ext flag; 0xF0 sets brk flag; neither produces code_valid.
REQ-023 Any other accepted byte: code_valid pulses in the cycle after the stop-bit edge cycle, code_byte/extended/released updated in that same cycle, ext and brk flags cleared.
REQ-024 Any frame_err clears ext and brk flags.
REQ-025 History: NUM_BYTES byte registers each with a valid bit; on code_valid with released=0 (or any code_valid if SHOW_BREAK=1) entry 0 takes code_byte, entry k takes entry k-1, oldest dropped, all shifted valid bits follow.
REQ-026 Digit 2k shows low nibble, digit 2k+1 high nibble of entry k via hex decoder 0-F (standard 7-segment glyphs, A b C d E F).
REQ-027 Digits of an invalid entry are blank (all segments off, respecting SEG_ACTIVE_LOW).
REQ-028 seg_out is registered; it changes the cycle after code_valid.
REQ-029 Consecutive frames back-to-back (stop edge followed by next start edge) are all received; no dead time required.

Reset
REQ-030 rst low asynchronously forces: FSM IDLE, counters 0, flags clear, all history invalid, code_valid=0, code_byte=0x00, extended=0, released=0, frame_err=0, seg_out all blank.
REQ-031 Reset mid-frame discards the partial frame; reception resumes at the next start bit after rst returns high.
REQ-032 Synchroniser flops reset to 1 (idle PS/2 line) so release of reset creates no false edge.

Structure
REQ-033 Shared package holds the 16-entry hex glyph constant table, blank constant, and prefix constants 0xE0/0xF0.
REQ-034 One sub-module, hex_to_7seg (4-bit in, 7-bit out, combinational), instantiated 2*NUM_BYTES times; receiver FSM and history stay in ps2_scan_display.

Verification
REQ-035 Frame 0x1C, valid parity -> code_valid once, code_byte=0x1C, extended=0, released=0; digits 1,0 show "1","C"; other digits blank.
REQ-036 Bytes F0,1C -> code_valid with released=1, code_byte=0x1C; history unchanged (SHOW_BREAK=0).
REQ-037 Bytes E0,75 then 0x16, NUM_BYTES=2 -> first code extended=1; display digits 3..0 = "7","5","1","6".
REQ-038 Frame 0x1C with wrong parity -> frame_err pulse, no code_valid, seg_out unchanged; following valid 0x32 received correctly.
REQ-039 Stop SCL after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE; next full frame 0x45 received correctly.
REQ-040 Assert rst mid-frame after 3 codes -> all outputs reset values, display blank; next frame 0x29 appears in digits 1,0 only.
